ins_dec_pipe: RTL and testbench

- Registered, parametrised instruction decode stage for the CPU datapath. It sits between instruction fetch and the register file/ALU.
- Accepts one instruction per cycle over a valid/ready handshake and splits it into control fields, using the same field semantics as the combinational decoder.
- Adds what the combinational decoder lacks: a decode output register with back-pressure, a one-cycle read-after-write hazard bubble, a halt/resume latch and a retired-instruction counter.

---
 rtl/ins_dec_pkg.sv | 33 +++
 rtl/ins_fields.sv | 39 +++
 rtl/ins_dec_pipe.sv | 173 +++++++++++++++++
 tb/tb_ins_dec_pipe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ins_dec_pkg.sv
// Shared field-layout helpers for the instruction decoders.
// Every offset is derived from the register-select width.
package ins_dec_pkg;

    function automatic int unsigned imm_w(input int unsigned reg_w);
        return 2 * reg_w;
    endfunction

    function automatic int unsigned ins_w(input int unsigned reg_w);
        return 3 * reg_w + 3;
    endfunction

    function automatic int unsigned halt_pos(input int unsigned reg_w);
        return 3 * reg_w + 2;
    endfunction

    function automatic int unsigned sel_data_pos(input int unsigned reg_w);
        return 3 * reg_w + 1;
    endfunction

    function automatic int unsigned alu_op_pos(input int unsigned reg_w);
        return 3 * reg_w;
    endfunction

    function automatic int unsigned sel_w_lo(input int unsigned reg_w);
        return 2 * reg_w;
    endfunction

    function automatic int unsigned sel_a_lo(input int unsigned reg_w);
        return reg_w;
    endfunction

endpackage

// File: rtl/ins_fields.sv
// Combinational field extraction and write-enable derivation for one instruction word.
// Shared between the combinational decoder and the pipelined decode stage.
module ins_fields
    import ins_dec_pkg::*;
#(
    parameter int unsigned REG_W = 2,
    localparam int unsigned IMM_W = imm_w(REG_W),
    localparam int unsigned INS_W = ins_w(REG_W)
) (
    input  logic [INS_W-1:0] ins_i,
    output logic             halt_o,
    output logic             sel_data_o,
    output logic             alu_op_o,
    output logic             write_en_o,
    output logic [REG_W-1:0] sel_w_o,
    output logic [REG_W-1:0] sel_a_o,
    output logic [REG_W-1:0] sel_b_o,
    output logic [IMM_W-1:0] imm_o
);

    localparam int unsigned HaltBit    = halt_pos(REG_W);
    localparam int unsigned SelDataBit = sel_data_pos(REG_W);
    localparam int unsigned AluOpBit   = alu_op_pos(REG_W);
    localparam int unsigned SelWLo     = sel_w_lo(REG_W);
    localparam int unsigned SelALo     = sel_a_lo(REG_W);

    always_comb begin
        halt_o     = ins_i[HaltBit];
        sel_data_o = ins_i[SelDataBit];
        alu_op_o   = ins_i[AluOpBit];
        sel_w_o    = ins_i[SelWLo +: REG_W];
        sel_a_o    = ins_i[SelALo +: REG_W];
        sel_b_o    = ins_i[0 +: REG_W];
        imm_o      = ins_i[0 +: IMM_W];
        // sel_data & alu_op together encode a no-writeback instruction
        write_en_o = ~(sel_data_o & alu_op_o) & ~halt_o;
    end

endmodule

// File: rtl/ins_dec_pipe.sv
// Registered decode stage: valid/ready output register, one-cycle RAW bubble,
// halt/resume latch and retired-instruction counter around ins_fields.
module ins_dec_pipe
    import ins_dec_pkg::*;
#(
    parameter int unsigned REG_W           = 2,
    parameter bit          STALL_ON_HAZARD = 1'b1,
    parameter int unsigned CNT_W           = 8,
    localparam int unsigned IMM_W = imm_w(REG_W),
    localparam int unsigned INS_W = ins_w(REG_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INS_W-1:0] INS,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel_data,
    output logic             write_en,
    output logic             alu_op,
    output logic [REG_W-1:0] SEL_A,
    output logic [REG_W-1:0] SEL_B,
    output logic [REG_W-1:0] SEL_W,
    output logic [IMM_W-1:0] IMM,
    output logic             halt,
    output logic             halted,
    input  logic             resume,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] ICNT
);

    logic             f_halt, f_sel_data, f_alu_op, f_write_en;
    logic [REG_W-1:0] f_sel_w, f_sel_a, f_sel_b;
    logic [IMM_W-1:0] f_imm;

    ins_fields #(
        .REG_W(REG_W)
    ) u_fields (
        .ins_i     (INS),
        .halt_o    (f_halt),
        .sel_data_o(f_sel_data),
        .alu_op_o  (f_alu_op),
        .write_en_o(f_write_en),
        .sel_w_o   (f_sel_w),
        .sel_a_o   (f_sel_a),
        .sel_b_o   (f_sel_b),
        .imm_o     (f_imm)
    );

    logic             out_valid_q, out_valid_d;
    logic             sel_data_q, sel_data_d;
    logic             write_en_q, write_en_d;
    logic             alu_op_q, alu_op_d;
    logic             halt_q, halt_d;
    logic [REG_W-1:0] sel_a_q, sel_a_d;
    logic [REG_W-1:0] sel_b_q, sel_b_d;
    logic [REG_W-1:0] sel_w_q, sel_w_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    logic             halted_q, halted_d;
    logic [REG_W-1:0] prev_w_q, prev_w_d;
    logic             prev_we_q, prev_we_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;

    logic adv, raw_hit, stall_now, accept;

    always_comb begin
        adv       = ~out_valid_q | out_ready;
        raw_hit   = (f_sel_a == prev_w_q) | (f_sel_b == prev_w_q);
        // Immediate loads read no registers, so they never hit a hazard
        stall_now = STALL_ON_HAZARD & in_valid & adv & prev_we_q & ~f_sel_data & raw_hit;
        in_ready     = adv & ~halted_q & ~stall_now;
        hazard_stall = stall_now;
        accept       = in_valid & in_ready;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        sel_data_d  = sel_data_q;
        write_en_d  = write_en_q;
        alu_op_d    = alu_op_q;
        halt_d      = halt_q;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        sel_w_d     = sel_w_q;
        imm_d       = imm_q;
        halted_d    = halted_q;
        prev_w_d    = prev_w_q;
        prev_we_d   = prev_we_q;
        icnt_d      = icnt_q;

        if (adv) begin
            out_valid_d = accept;
            if (accept) begin
                sel_data_d = f_sel_data;
                write_en_d = f_write_en;
                alu_op_d   = f_alu_op;
                halt_d     = f_halt;
                sel_a_d    = f_sel_a;
                sel_b_d    = f_sel_b;
                sel_w_d    = f_sel_w;
                imm_d      = f_imm;
            end else begin
                // Never leave a stale write strobe on an empty slot
                write_en_d = 1'b0;
                halt_d     = 1'b0;
            end
        end

        if (stall_now || (accept && f_halt)) begin
            prev_w_d  = '0;
            prev_we_d = 1'b0;
        end else if (accept) begin
            prev_w_d  = f_sel_w;
            prev_we_d = f_write_en;
        end

        if (accept && f_halt) begin
            halted_d = 1'b1;
        end else if (halted_q && resume) begin
            halted_d = 1'b0;
        end

        if (accept && !f_halt) begin
            icnt_d = icnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sel_data_q  <= 1'b0;
            write_en_q  <= 1'b0;
            alu_op_q    <= 1'b0;
            halt_q      <= 1'b0;
            sel_a_q     <= '0;
            sel_b_q     <= '0;
            sel_w_q     <= '0;
            imm_q       <= '0;
            halted_q    <= 1'b0;
            prev_w_q    <= '0;
            prev_we_q   <= 1'b0;
            icnt_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sel_data_q  <= sel_data_d;
            write_en_q  <= write_en_d;
            alu_op_q    <= alu_op_d;
            halt_q      <= halt_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            sel_w_q     <= sel_w_d;
            imm_q       <= imm_d;
            halted_q    <= halted_d;
            prev_w_q    <= prev_w_d;
            prev_we_q   <= prev_we_d;
            icnt_q      <= icnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sel_data  = sel_data_q;
    assign write_en  = write_en_q;
    assign alu_op    = alu_op_q;
    assign halt      = halt_q;
    assign SEL_A     = sel_a_q;
    assign SEL_B     = sel_b_q;
    assign SEL_W     = sel_w_q;
    assign IMM       = imm_q;
    assign halted    = halted_q;
    assign ICNT      = icnt_q;

endmodule

// File: tb/tb_ins_dec_pipe.sv
// Directed bench for ins_dec_pipe: cycle table plus hand sequences for reset,
// the no-stall variant, reset while halted and counter wrap.
module tb_ins_dec_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic       resume;
    logic [8:0] ins;

    logic       in_ready, out_valid, sel_data, write_en, alu_op, halt, halted, hazard_stall;
    logic [1:0] sel_a, sel_b, sel_w;
    logic [3:0] imm;
    logic [7:0] icnt;

    logic       ns_in_ready, ns_out_valid, ns_sel_data, ns_write_en, ns_alu_op;
    logic       ns_halt, ns_halted, ns_hazard_stall;
    logic [1:0] ns_sel_a, ns_sel_b, ns_sel_w;
    logic [3:0] ns_imm;
    logic [7:0] ns_icnt;

    int checks = 0;
    int errors = 0;

    ins_dec_pipe #(
        .REG_W(2),
        .STALL_ON_HAZARD(1'b1),
        .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .INS(ins),
        .out_valid(out_valid), .out_ready(out_ready), .sel_data(sel_data),
        .write_en(write_en), .alu_op(alu_op), .SEL_A(sel_a), .SEL_B(sel_b), .SEL_W(sel_w),
        .IMM(imm), .halt(halt), .halted(halted), .resume(resume),
        .hazard_stall(hazard_stall), .ICNT(icnt)
    );

    ins_dec_pipe #(
        .REG_W(2),
        .STALL_ON_HAZARD(1'b0),
        .CNT_W(8)
    ) dut_ns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ns_in_ready), .INS(ins),
        .out_valid(ns_out_valid), .out_ready(out_ready), .sel_data(ns_sel_data),
        .write_en(ns_write_en), .alu_op(ns_alu_op), .SEL_A(ns_sel_a), .SEL_B(ns_sel_b),
        .SEL_W(ns_sel_w), .IMM(ns_imm), .halt(ns_halt), .halted(ns_halted),
        .resume(resume), .hazard_stall(ns_hazard_stall), .ICNT(ns_icnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [8:0] IA = 9'b0_00_01_00_01;  // reg op, W=01
    localparam logic [8:0] IB = 9'b0_00_10_01_11;  // reads 01 -> RAW on IA
    localparam logic [8:0] IC = 9'b0_10_11_01_01;  // immediate load, W=11
    localparam logic [8:0] ID = 9'b0_11_00_11_11;  // no write-back
    localparam logic [8:0] IE = 9'b0_00_10_00_00;  // reads 00, W=10
    localparam logic [8:0] IF = 9'b0_00_00_10_10;  // reads 10, W=00
    localparam logic [8:0] IH = 9'b1_00_00_00_00;  // halt

    typedef struct {
        logic [8:0] ins;
        logic       v;
        logic       r;
        logic       res;
        logic       e_ir;
        logic       e_hs;
        logic       e_ov;
        logic       e_halted;
        logic [7:0] e_icnt;
        logic [8:0] e_ins;
        logic       e_we;
    } row_t;

    localparam int NV = 26;
    row_t vec[NV];

    function automatic row_t mk(input logic [8:0] i, input logic v, input logic r,
                                input logic res, input logic ir, input logic hs,
                                input logic ov, input logic hd, input logic [7:0] cnt,
                                input logic [8:0] ei, input logic we);
        row_t t;
        t.ins = i; t.v = v; t.r = r; t.res = res;
        t.e_ir = ir; t.e_hs = hs; t.e_ov = ov; t.e_halted = hd;
        t.e_icnt = cnt; t.e_ins = ei; t.e_we = we;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic v, input logic [8:0] i,
                         input logic r, input logic res);
        @(negedge clk);
        rst_n = rn; in_valid = v; ins = i; out_ready = r; resume = res;
        #3;
    endtask

    initial begin
        //           ins  v  r  res ir hs ov hd icnt  e_ins e_we
        vec[0]  = mk(IA, 1, 1, 0,  1, 0, 0, 0, 0,    '0,   0);
        vec[1]  = mk(IB, 1, 1, 0,  0, 1, 1, 0, 1,    IA,   1);
        vec[2]  = mk(IB, 1, 1, 0,  1, 0, 0, 0, 1,    '0,   0);
        vec[3]  = mk(IC, 1, 1, 0,  1, 0, 1, 0, 2,    IB,   1);
        vec[4]  = mk(ID, 1, 1, 0,  1, 0, 1, 0, 3,    IC,   1);
        vec[5]  = mk(IE, 1, 1, 0,  1, 0, 1, 0, 4,    ID,   0);
        vec[6]  = mk(IF, 1, 0, 0,  0, 0, 1, 0, 5,    IE,   1);
        vec[7]  = mk(IF, 1, 0, 0,  0, 0, 1, 0, 5,    IE,   1);
        vec[8]  = mk(IF, 1, 0, 0,  0, 0, 1, 0, 5,    IE,   1);
        vec[9]  = mk(IF, 1, 1, 0,  0, 1, 1, 0, 5,    IE,   1);
        vec[10] = mk(IF, 1, 1, 0,  1, 0, 0, 0, 5,    '0,   0);
        vec[11] = mk(IC, 1, 1, 0,  1, 0, 1, 0, 6,    IF,   1);
        vec[12] = mk(ID, 1, 1, 0,  1, 0, 1, 0, 7,    IC,   1);
        vec[13] = mk('0, 0, 1, 0,  1, 0, 1, 0, 8,    ID,   0);
        vec[14] = mk('0, 0, 1, 0,  1, 0, 0, 0, 8,    '0,   0);
        vec[15] = mk(IH, 1, 1, 0,  1, 0, 0, 0, 8,    '0,   0);
        vec[16] = mk(IA, 1, 1, 0,  0, 0, 1, 1, 8,    IH,   0);
        vec[17] = mk(IA, 1, 1, 0,  0, 0, 0, 1, 8,    '0,   0);
        vec[18] = mk(IA, 1, 1, 0,  0, 0, 0, 1, 8,    '0,   0);
        vec[19] = mk(IA, 1, 1, 0,  0, 0, 0, 1, 8,    '0,   0);
        vec[20] = mk(IA, 1, 1, 0,  0, 0, 0, 1, 8,    '0,   0);
        vec[21] = mk(IA, 1, 1, 1,  0, 0, 0, 1, 8,    '0,   0);
        vec[22] = mk(IA, 1, 1, 0,  1, 0, 0, 0, 8,    '0,   0);
        vec[23] = mk('0, 0, 1, 1,  1, 0, 1, 0, 9,    IA,   1);
        vec[24] = mk(IH, 1, 1, 1,  1, 0, 0, 0, 9,    '0,   0);
        vec[25] = mk('0, 0, 1, 0,  0, 0, 1, 1, 9,    IH,   0);

        rst_n = 1'b0; in_valid = 1'b0; ins = '0; out_ready = 1'b1; resume = 1'b0;

        // Reset held two cycles with in_valid high, then released
        drive(0, 1, IA, 1, 0);
        drive(0, 1, IA, 1, 0);
        drive(1, 0, '0, 1, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst write_en", write_en, 0);
        chk("rst icnt", icnt, 0);
        chk("rst halted", halted, 0);
        chk("rst in_ready", in_ready, 1);

        // Same RAW pair on both instances: only the stalling one bubbles
        drive(1, 1, IA, 1, 0);
        drive(1, 1, IB, 1, 0);
        chk("ns in_ready", ns_in_ready, 1);
        chk("ns hazard_stall", ns_hazard_stall, 0);
        chk("st hazard_stall", hazard_stall, 1);
        drive(1, 0, '0, 1, 0);
        chk("ns out_valid", ns_out_valid, 1);
        chk("ns sel_w", ns_sel_w, 2'b10);
        chk("ns icnt", ns_icnt, 2);
        drive(0, 0, '0, 1, 0);

        for (int i = 0; i < NV; i++) begin
            drive(1, vec[i].v, vec[i].ins, vec[i].r, vec[i].res);
            chk($sformatf("r%0d in_ready", i), in_ready, vec[i].e_ir);
            chk($sformatf("r%0d hazard_stall", i), hazard_stall, vec[i].e_hs);
            chk($sformatf("r%0d out_valid", i), out_valid, vec[i].e_ov);
            chk($sformatf("r%0d halted", i), halted, vec[i].e_halted);
            chk($sformatf("r%0d icnt", i), icnt, vec[i].e_icnt);
            if (vec[i].e_ov) begin
                chk($sformatf("r%0d write_en", i), write_en, vec[i].e_we);
                chk($sformatf("r%0d ctl", i), {halt, sel_data, alu_op}, vec[i].e_ins[8:6]);
                chk($sformatf("r%0d sels", i), {sel_w, sel_a, sel_b}, vec[i].e_ins[5:0]);
                chk($sformatf("r%0d imm", i), imm, vec[i].e_ins[3:0]);
            end
        end

        // Reset while halted
        drive(0, 0, '0, 1, 0);
        drive(1, 0, '0, 1, 0);
        chk("halt rst halted", halted, 0);
        chk("halt rst icnt", icnt, 0);
        chk("halt rst out_valid", out_valid, 0);
        chk("halt rst in_ready", in_ready, 1);

        // Counter wraps after 256 accepted instructions
        for (int i = 0; i < 256; i++) begin
            drive(1, 1, IC, 1, 0);
            if (i == 255) begin
                chk("wrap icnt 255", icnt, 255);
            end
        end
        drive(1, 0, '0, 1, 0);
        chk("wrap icnt 0", icnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
